sqrt_scheduler: RTL and testbench

Shared-resource scheduler for the batch-norm square-root unit: arbitrates up to N_REQ per-channel requesters (variance + epsilon operands, FP16) onto a single iterative square-root core. Each operation restarts the core, runs a fixed number of cycles, captures the result and returns it tagged with the requester ID. Sits between the BN parameter-precompute lanes and the one square-root instance in the BN block.

---
 rtl/sqrt_scheduler.sv | 164 ++++++++++++++++
 tb/tb_sqrt_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_scheduler.sv
// sqrt_scheduler: round-robin arbiter that shares one iterative square-root core among N_REQ requesters.
// Optional feature macro: SQRT_SCHED_ZERO_BYPASS_EN (answer +/-0 operands directly, without the core).
module sqrt_scheduler #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ID_WIDTH    = 2,
  parameter int unsigned ITER_CYCLES = 10
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [(1<<ID_WIDTH)-1:0]              req,
  input  logic [(1<<ID_WIDTH)*DATA_WIDTH-1:0]   req_x,
  output logic [(1<<ID_WIDTH)-1:0]              req_ack,
  output logic [DATA_WIDTH-1:0]                 sq_x,
  output logic                                  sq_reset,
  input  logic [DATA_WIDTH-1:0]                 sq_out,
  output logic                                  rsp_valid,
  output logic [ID_WIDTH-1:0]                   rsp_id,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic                                  busy
);

  localparam int unsigned N_REQ = 1 << ID_WIDTH;
  localparam int unsigned CNT_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ID_WIDTH-1:0]   r_last_grant;
  logic [N_REQ-1:0]      r_req_ack;
  logic [DATA_WIDTH-1:0] r_sq_x;
  logic                  r_sq_reset;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [ID_WIDTH-1:0]   w_last_nxt;
  logic [N_REQ-1:0]      w_ack_nxt;
  logic [DATA_WIDTH-1:0] w_sq_x_nxt;
  logic                  w_sq_reset_nxt;
  logic                  w_rsp_valid_nxt;
  logic [ID_WIDTH-1:0]   w_rsp_id_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_data_nxt;

  logic                  w_grant_vld;
  logic [ID_WIDTH-1:0]   w_grant_id;
  logic [ID_WIDTH-1:0]   w_cand;
  logic [DATA_WIDTH-1:0] w_grant_x;
`ifdef SQRT_SCHED_ZERO_BYPASS_EN
  logic                  w_grant_zero;
`endif

  // Round-robin search: the requester after the last winner has highest priority.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = r_last_grant + ID_WIDTH'(k);
      if (!w_grant_vld && req[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand;
      end
    end
  end

  assign w_grant_x = req_x[int'(w_grant_id) * int'(DATA_WIDTH) +: DATA_WIDTH];
`ifdef SQRT_SCHED_ZERO_BYPASS_EN
  assign w_grant_zero = (w_grant_x[DATA_WIDTH-2:0] == '0);
`endif

  // Next-state and next-output logic; the core is held in restart whenever it is not running.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last_grant;
    w_ack_nxt       = '0;
    w_sq_x_nxt      = r_sq_x;
    w_sq_reset_nxt  = 1'b1;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_ack_nxt[w_grant_id] = 1'b1;
          w_last_nxt            = w_grant_id;
          w_rsp_id_nxt          = w_grant_id;
`ifdef SQRT_SCHED_ZERO_BYPASS_EN
          if (w_grant_zero) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = w_grant_x;
          end else begin
            w_sq_x_nxt  = w_grant_x;
            w_state_nxt = S_LOAD;
          end
`else
          w_sq_x_nxt  = w_grant_x;
          w_state_nxt = S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        w_sq_reset_nxt = 1'b0;
        w_cnt_nxt      = '0;
        w_state_nxt    = S_RUN;
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = sq_out;
          w_state_nxt     = S_IDLE;
        end else begin
          w_sq_reset_nxt = 1'b0;
          w_cnt_nxt      = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= ID_WIDTH'(N_REQ - 1);
      r_req_ack    <= '0;
      r_sq_x       <= '0;
      r_sq_reset   <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_nxt;
      r_req_ack    <= w_ack_nxt;
      r_sq_x       <= w_sq_x_nxt;
      r_sq_reset   <= w_sq_reset_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_id     <= w_rsp_id_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign req_ack   = r_req_ack;
  assign sq_x      = r_sq_x;
  assign sq_reset  = r_sq_reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb_sqrt_scheduler: transaction-level reference model (grant times, response times) checked every cycle.
module tb_sqrt_scheduler;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;
  localparam int unsigned NR = 1 << IW;
  localparam int unsigned IT = 10;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_x;
  logic [NR-1:0]   req_ack;
  logic [DW-1:0]   sq_x;
  logic            sq_reset;
  logic [DW-1:0]   sq_out;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  sqrt_scheduler #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .ITER_CYCLES(IT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_ack(req_ack),
    .sq_x(sq_x), .sq_reset(sq_reset), .sq_out(sq_out), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in core: result is only meaningful in the ITER_CYCLES-th cycle with its restart low.
  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] x);
    case (x)
      16'h4400: return 16'h4000;
      16'h4C00: return 16'h4400;
      16'h4880: return 16'h4200;
      16'h3400: return 16'h3800;
      16'h8000: return 16'h8000;
      16'h0000: return 16'h0000;
      default:  return x ^ 16'h5A3C;
    endcase
  endfunction

  int core_cnt = 0;
  always @(posedge clk) core_cnt <= sq_reset ? 0 : core_cnt + 1;
  assign sq_out = (!sq_reset && core_cnt == int'(IT) - 1) ? core_fn(sq_x) : 16'hFFFF;

  typedef struct {
    int            cyc;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           ack_q[$];
  ev_t           rsp_q[$];
  int            m_last  = NR - 1;
  int            m_free  = 0;
  int            m_start = -100;
  logic [DW-1:0] m_x     = '0;
  logic [NR-1:0] e_ack   = '0;
  logic [NR-1:0] hold    = '0;
  logic [NR-1:0] rearm   = '0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_ack",   32'(req_ack),   32'(0));
    check("rst_sq_x",      32'(sq_x),      32'(0));
    check("rst_sq_reset",  32'(sq_reset),  32'(1));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id",    32'(rsp_id),    32'(0));
    check("rst_rsp_data",  32'(rsp_data),  32'(0));
    check("rst_busy",      32'(busy),      32'(0));
  endtask

  // Compare this cycle's outputs with the model, then let requesters react to their grants.
  task automatic cyc_begin();
    int            c;
    logic          ev;
    logic [IW-1:0] eid;
    logic [DW-1:0] edata;
    logic          e_busy;
    logic          e_sqr;
    @(negedge clk);
    c = cyc;
    e_ack = '0;
    ev    = 1'b0;
    eid   = '0;
    edata = '0;
    while (ack_q.size() > 0 && ack_q[0].cyc < c) void'(ack_q.pop_front());
    while (rsp_q.size() > 0 && rsp_q[0].cyc < c) void'(rsp_q.pop_front());
    if (ack_q.size() > 0 && ack_q[0].cyc == c) begin
      e_ack[ack_q[0].id] = 1'b1;
      void'(ack_q.pop_front());
    end
    if (rsp_q.size() > 0 && rsp_q[0].cyc == c) begin
      ev    = 1'b1;
      eid   = rsp_q[0].id;
      edata = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    e_busy = (c > m_start) && (c < m_free);
    e_sqr  = !((c > m_start + 1) && (c < m_free));
    check("req_ack",   32'(req_ack),   32'(e_ack));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      check("rsp_id",   32'(rsp_id),   32'(eid));
      check("rsp_data", 32'(rsp_data), 32'(edata));
    end
    check("busy",     32'(busy),     32'(e_busy));
    check("sq_reset", 32'(sq_reset), 32'(e_sqr));
    if (e_busy) check("sq_x", 32'(sq_x), 32'(m_x));
    for (int i = 0; i < int'(NR); i++) begin
      if (e_ack[i]) begin
        req[i]   = 1'b0;
        rearm[i] = hold[i];
      end else if (rearm[i]) begin
        req[i]   = 1'b1;
        rearm[i] = 1'b0;
      end
    end
  endtask

  // Reference arbitration: a free unit grants round-robin and answers ITER_CYCLES+2 cycles later.
  task automatic model_eval();
    int            c;
    int            g;
    logic [DW-1:0] x;
    ev_t           e;
    c = cyc;
    g = -1;
    if (reset && c >= m_free && req != '0) begin
      for (int k = 1; k <= int'(NR); k++)
        if (g < 0 && req[(m_last + k) % int'(NR)]) g = (m_last + k) % int'(NR);
      x      = req_x[g*int'(DW) +: DW];
      m_last = g;
      e.cyc  = c + 1;
      e.id   = IW'(g);
      e.data = '0;
      ack_q.push_back(e);
`ifdef SQRT_SCHED_ZERO_BYPASS_EN
      if (x[DW-2:0] == '0) begin
        e.data = x;
        rsp_q.push_back(e);
        return;
      end
`endif
      m_x     = x;
      m_start = c;
      m_free  = c + int'(IT) + 2;
      e.cyc   = c + int'(IT) + 2;
      e.data  = core_fn(x);
      rsp_q.push_back(e);
    end
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    #1;
    check_reset_vals();
    ack_q.delete();
    rsp_q.delete();
    m_last  = NR - 1;
    m_free  = cyc;
    m_start = -100;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cyc_begin();
      model_eval();
    end
  endtask

  task automatic raise(input int i, input logic [DW-1:0] x);
    req[i] = 1'b1;
    req_x[i*int'(DW) +: DW] = x;
  endtask

  task automatic pulse_reset();
    cyc_begin();
    assert_reset();
    model_eval();
    run(1);
    cyc_begin();
    reset = 1'b1;
    model_eval();
  endtask

  function automatic logic [DW-1:0] pick_operand();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'h8000;
    return DW'($urandom);
  endfunction

  initial begin
    req   = '0;
    req_x = '0;
    cyc_begin();
    check_reset_vals();
    model_eval();
    run(2);
    cyc_begin();
    reset = 1'b1;
    model_eval();

    // single request
    cyc_begin(); raise(0, 16'h4400); model_eval();
    run(15);

    // all four at once, fresh arbitration history
    pulse_reset();
    cyc_begin();
    raise(0, 16'h4400); raise(1, 16'h4C00); raise(2, 16'h4880); raise(3, 16'h3400);
    model_eval();
    run(4 * (int'(IT) + 2) + 4);

    // fairness between two persistent requesters
    cyc_begin();
    hold[1] = 1'b1; hold[3] = 1'b1;
    raise(1, 16'h4C00); raise(3, 16'h3400);
    model_eval();
    run(6 * (int'(IT) + 2));
    cyc_begin();
    hold = '0; rearm = '0; req = '0;
    model_eval();
    run(14);

    // reset in the sixth RUN cycle with requester 2 pending
    cyc_begin(); raise(0, 16'h4C00); model_eval();
    run(5);
    cyc_begin(); raise(2, 16'h3400); model_eval();
    cyc_begin(); assert_reset(); model_eval();
    run(2);
    cyc_begin(); reset = 1'b1; model_eval();
    run(15);

    // withdrawn request while busy
    cyc_begin(); raise(0, 16'h4880); model_eval();
    run(3);
    cyc_begin(); raise(1, 16'h1234); model_eval();
    run(2);
    cyc_begin(); req[1] = 1'b0; model_eval();
    run(12);

    // zero operands
    cyc_begin(); raise(2, 16'h8000); model_eval();
    run(15);
    cyc_begin(); raise(1, 16'h0000); raise(3, 16'h3C00); model_eval();
    run(30);

    // random traffic with occasional withdrawals
    for (int n = 0; n < 400; n++) begin
      cyc_begin();
      for (int i = 0; i < int'(NR); i++) begin
        if (!req[i] && $urandom_range(0, 9) == 0) raise(i, pick_operand());
        else if (req[i] && $urandom_range(0, 59) == 0) req[i] = 1'b0;
      end
      model_eval();
    end
    cyc_begin(); req = '0; model_eval();
    run(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
